// File: rtl/systolic_feeder.sv
// systolic_feeder
//
// Edge driver for an N x N output-stationary systolic MAC array. Each cycle
// exactly one beat {rst, x[N], w[N]} enters a shared stage-0 register: an
// accepted operand beat, a zero bubble, or a flush beat (rst=1, operands 0).
// From stage 0, lane i passes through i+1 further registers. This gives the
// diagonal skew, so that a beat accepted at edge c reaches lane i after edge
// c+1+i. After the last beat of each tile, one flush beat is inserted. It
// sweeps the array as a reset wavefront, and each PE dumps and clears its
// accumulator when that wavefront reaches it.
//
// Optional feature macro: FEEDER_AUTOFLUSH_EN. When it is defined, a tile
// that reaches KMAX accepted beats without in_last is force-terminated, and
// err_overrun latches until reset. When it is undefined, tiles end only on
// in_last and err_overrun is tied low.
//
// Handshake: a beat is transferred on a rising clk edge where
// in_valid && in_ready. in_ready does not depend on in_valid. in_ready is
// low during reset, low on the first edge after reset, and low in the single
// FLUSH cycle. The array downstream never applies backpressure.
//
// Ports
//   clk          clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   in_valid     operand beat valid
//   in_ready     feeder accepts a beat this cycle
//   in_x         x column, lane i = [i*DEP +: DEP], signed
//   in_w         w row,    lane j = [j*DEP +: DEP], signed
//   in_last      last beat of the tile (ignored without in_valid)
//   x_left       to x_in of PE(i,0), lane i
//   w_top        to w_in of PE(0,j), lane j
//   rst_left     to rst_in_left of PE(i,0)
//   rst_top      to rst_in_up of PE(0,j)
//   tile_done    one-cycle pulse while the flush occupies lane N-1
//   err_overrun  sticky autoflush indicator
//   state        FSM state (debug observation)

module systolic_feeder #(
  parameter int DEP  = 8,
  parameter int N    = 4,
  parameter int KMAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*DEP-1:0] in_x,
  input  logic [N*DEP-1:0] in_w,
  input  logic             in_last,
  output logic [N*DEP-1:0] x_left,
  output logic [N*DEP-1:0] w_top,
  output logic [N-1:0]     rst_left,
  output logic [N-1:0]     rst_top,
  output logic             tile_done,
  output logic             err_overrun,
  output logic [0:0]       state
);

  localparam logic [0:0] ST_STREAM = 1'b0;
  localparam logic [0:0] ST_FLUSH  = 1'b1;

  if (N < 1 || KMAX < 1) begin : g_param_check
    $error("systolic_feeder: N and KMAX must both be at least 1");
  end

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       up_q;       // low only until the first edge after reset
  logic       accept;
  logic       go_flush;
  logic       flushing;

  assign flushing = (state_q == ST_FLUSH);
  assign in_ready = up_q & ~flushing;
  assign accept   = in_valid & in_ready;
  assign state    = state_q;

`ifdef FEEDER_AUTOFLUSH_EN
  localparam int CNT_W = $clog2(KMAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             overrun;
  logic             err_q;

  // The KMAX-th beat arrives when KMAX-1 beats have already been counted.
  assign overrun     = accept & ~in_last & (cnt_q == CNT_W'(KMAX - 1));
  assign go_flush    = (accept & in_last) | overrun;
  assign err_overrun = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (flushing) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (overrun) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign go_flush    = accept & in_last;
  assign err_overrun = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STREAM: if (go_flush) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_STREAM;
      default:   state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STREAM;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= 1'b1;
    end
  end

  // Stage 0 holds the beat entering the skew line this cycle. Operands are
  // zeroed for bubbles and flushes, so the PEs accumulate nothing then.
  logic [N*DEP-1:0] s0_x;
  logic [N*DEP-1:0] s0_w;
  logic             s0_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_x <= '0;
      s0_w <= '0;
      s0_r <= 1'b0;
    end else begin
      s0_x <= accept ? in_x : '0;
      s0_w <= accept ? in_w : '0;
      s0_r <= flushing;
    end
  end

  // Lane i delays stage 0 by i+1 more registers.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DEP-1:0] xp [0:i];
    logic [DEP-1:0] wp [0:i];
    logic           rp [0:i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) begin
          xp[k] <= '0;
          wp[k] <= '0;
          rp[k] <= 1'b0;
        end
      end else begin
        xp[0] <= s0_x[i*DEP +: DEP];
        wp[0] <= s0_w[i*DEP +: DEP];
        rp[0] <= s0_r;
        for (int k = 1; k <= i; k++) begin
          xp[k] <= xp[k-1];
          wp[k] <= wp[k-1];
          rp[k] <= rp[k-1];
        end
      end
    end

    assign x_left[i*DEP +: DEP] = xp[i];
    assign w_top[i*DEP +: DEP]  = wp[i];
    // Both edges of the array are fed from the same bit. PE(i,j) therefore
    // sees the flush from the left and from the top in the same cycle.
    assign rst_left[i] = rp[i];
    assign rst_top[i]  = rp[i];
  end

  // tile_done is high while the flush occupies the deepest lane.
  assign tile_done = rst_left[N-1];

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
//
// Bench for systolic_feeder with N=4, DEP=8 and KMAX=4. The reference model
// keeps a history of the beat that enters the skew line at every edge,
// indexed by edge number. Each expected output is read from that history:
// lane i after edge e shows beat[e-1-i], and tile_done shows beat[e-N].rst.
// A small output-stationary PE array model checks the accumulated results
// of a tile. Build with +define+FEEDER_AUTOFLUSH_EN to exercise the autoflush
// scenarios.

module tb_systolic_feeder;
  localparam int DEP  = 8;
  localparam int N    = 4;
  localparam int KMAX = 4;
  localparam int W    = N * DEP;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_w;
  logic           in_last;
  logic [W-1:0]   x_left;
  logic [W-1:0]   w_top;
  logic [N-1:0]   rst_left;
  logic [N-1:0]   rst_top;
  logic           tile_done;
  logic           err_overrun;
  logic [0:0]     state;

  systolic_feeder #(.DEP(DEP), .N(N), .KMAX(KMAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_last(in_last), .x_left(x_left),
    .w_top(w_top), .rst_left(rst_left), .rst_top(rst_top),
    .tile_done(tile_done), .err_overrun(err_overrun), .state(state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Beat history: one entry per edge since the last reset.
  logic [W-1:0] hx [0:4095];
  logic [W-1:0] hw [0:4095];
  logic         hr [0:4095];
  int           ed;
  bit           m_up;
  bit           m_flush;
  int           m_cnt;
  bit           m_err;

  // Recorded outputs used by the PE array model.
  bit           rec_en;
  int           rec_t;
  logic [W-1:0] obs_x [0:63];
  logic [W-1:0] obs_w [0:63];
  logic [N-1:0] obs_r [0:63];

  task automatic model_reset();
    ed      = 0;
    m_up    = 0;
    m_flush = 0;
    m_cnt   = 0;
    m_err   = 0;
  endtask

  task automatic check_outputs();
    logic [W-1:0] ex, ew;
    logic [N-1:0] er;
    logic         ed_done;
    ex = '0; ew = '0; er = '0; ed_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = ed - 2 - i;
      if (idx >= 0) begin
        ex[i*DEP +: DEP] = hx[idx][i*DEP +: DEP];
        ew[i*DEP +: DEP] = hw[idx][i*DEP +: DEP];
        er[i]            = hr[idx];
      end
    end
    if (ed - 1 - N >= 0) ed_done = hr[ed-1-N];
    check_eq("x_left", 64'(x_left), 64'(ex));
    check_eq("w_top", 64'(w_top), 64'(ew));
    check_eq("rst_left", 64'(rst_left), 64'(er));
    check_eq("rst_top", 64'(rst_top), 64'(er));
    check_eq("tile_done", 64'(tile_done), 64'(ed_done));
    check_eq("err_overrun", 64'(err_overrun), 64'(m_err));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge. Presents one cycle of input, then models the edge
  // and checks the outputs at the following negedge.
  task automatic step(input bit v, input logic [W-1:0] x, input logic [W-1:0] w, input bit last);
    bit acc;
    in_valid = v;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(m_up && !m_flush));
    @(posedge clk);
    acc = v && m_up && !m_flush;
    if (m_flush) begin
      hx[ed] = '0; hw[ed] = '0; hr[ed] = 1'b1;
      m_flush = 0;
      m_cnt   = 0;
    end else if (acc) begin
      hx[ed] = x; hw[ed] = w; hr[ed] = 1'b0;
      m_cnt++;
      if (last) begin
        m_flush = 1;
      end
`ifdef FEEDER_AUTOFLUSH_EN
      else if (m_cnt == KMAX) begin
        m_flush = 1;
        m_err   = 1;
      end
`endif
    end else begin
      hx[ed] = '0; hw[ed] = '0; hr[ed] = 1'b0;
    end
    if (ed < 4095) ed++;
    m_up = 1;
    @(negedge clk);
    check_outputs();
    if (rec_en && rec_t < 64) begin
      obs_x[rec_t] = x_left;
      obs_w[rec_t] = w_top;
      obs_r[rec_t] = rst_left;
      rec_t++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0, 0);
  endtask

  // Asserts reset mid-cycle and checks that all outputs clear at once.
  // Returns at a negedge with rst_n released.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_x_left", 64'(x_left), 64'd0);
    check_eq("rst_w_top", 64'(w_top), 64'd0);
    check_eq("rst_rst_left", 64'(rst_left), 64'd0);
    check_eq("rst_rst_top", 64'(rst_top), 64'd0);
    check_eq("rst_tile_done", 64'(tile_done), 64'd0);
    check_eq("rst_err", 64'(err_overrun), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // PE(i,j) sees x_left[i] delayed j cycles and w_top[j] delayed i cycles.
  // It sums products until the flush reaches it, and that sum is its y_out.
  task automatic pe_array_check(input int expect_y);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int  acc, res;
        bit  done;
        acc = 0; res = -1; done = 0;
        for (int t = 0; t < rec_t; t++) begin
          int tx, tw, xv, wv;
          bit rl, rt;
          tx = t - j; tw = t - i;
          xv = 0; wv = 0; rl = 0; rt = 0;
          if (tx >= 0) begin
            xv = int'($signed(obs_x[tx][i*DEP +: DEP]));
            rl = obs_r[tx][i];
          end
          if (tw >= 0) begin
            wv = int'($signed(obs_w[tw][j*DEP +: DEP]));
            rt = obs_r[tw][j];
          end
          if (!done && (rl || rt)) begin
            check_eq($sformatf("pe_rst_align_%0d_%0d", i, j), 64'(rl), 64'(rt));
            res  = acc;
            done = 1;
          end else if (!done) begin
            acc += xv * wv;
          end
        end
        check_eq($sformatf("pe_y_%0d_%0d", i, j), 64'(res), 64'(expect_y));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] ones;
  logic [W-1:0] rx, rw;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_x = '0; in_w = '0; in_last = 0;
    rec_en = 0; rec_t = 0;
    model_reset();
    ones = '0;
    for (int i = 0; i < N; i++) ones[i*DEP +: DEP] = 8'd1;

    // Reset, then the ready ramp after release.
    do_reset();
    idle(2);

    // Skew: a single beat with distinct lane values.
    step(1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
    idle(N + 2);

    // Tile flush: 3 all-ones beats, through the PE array model.
    rec_en = 1; rec_t = 0;
    step(1, ones, ones, 0);
    step(1, ones, ones, 0);
    step(1, ones, ones, 1);
    idle(12);
    rec_en = 0;
    pe_array_check(3);

    // Back-to-back: 1-beat tile, then the next tile is held until accepted.
    step(1, {4{8'h80}}, {4{8'hFF}}, 1);
    step(1, {4{8'h11}}, {4{8'h22}}, 0);
    step(1, {4{8'h11}}, {4{8'h22}}, 1);
    idle(N + 3);

    // Reset mid-tile, then a clean tile with the same timing as before.
    step(1, ones, ones, 0);
    step(1, ones, ones, 0);
    do_reset();
    idle(1);
    rec_en = 1; rec_t = 0;
    step(1, ones, ones, 0);
    step(1, ones, ones, 0);
    step(1, ones, ones, 1);
    idle(12);
    rec_en = 0;
    pe_array_check(3);

`ifdef FEEDER_AUTOFLUSH_EN
    // Overrun: KMAX beats without in_last force a flush and latch the error.
    for (int k = 0; k < KMAX; k++) step(1, ones, ones, 0);
    step(1, ones, ones, 0);
    idle(N + 3);
    check_eq("err_sticky", 64'(err_overrun), 64'd1);
    do_reset();
    idle(1);
    // Normal termination on the KMAX-th beat leaves the error clear.
    for (int k = 0; k < KMAX; k++) step(1, ones, ones, k == KMAX - 1);
    idle(N + 3);
    check_eq("err_clear", 64'(err_overrun), 64'd0);
`endif

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rx = W'($urandom);
      rw = W'($urandom);
      step($urandom_range(0, 3) != 0, rx, rw, $urandom_range(0, 4) == 0);
    end
    idle(N + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
